// File: rtl/cpu_csr_pkg.sv
// rtl/cpu_csr_pkg.sv - shared CSR addresses, cause codes, FSM state and writeback select
package cpu_csr_pkg;

  localparam logic [11:0] CSR_SSCRATCH = 12'h140;
  localparam logic [11:0] CSR_SEPC     = 12'h141;
  localparam logic [11:0] CSR_SCAUSE   = 12'h142;
  localparam logic [11:0] CSR_STVEC    = 12'h105;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;

  localparam logic [7:0] CAUSE_ECALL   = 8'h08;
  localparam logic [7:0] CAUSE_ILLEGAL = 8'h02;

  localparam logic [1:0] WDSEL_CSR = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_REDIR = 1'b1
  } trap_state_t;

endpackage

// File: rtl/csr_file.sv
// rtl/csr_file.sv - supervisor trap CSR storage, read mux and set-bits write port
module csr_file
  import cpu_csr_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     addr,
  output logic [XLEN-1:0] rdata,
  input  logic            set_en,
  input  logic [XLEN-1:0] set_mask,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [7:0]      trap_cause,
  output logic [XLEN-1:0] stvec,
  output logic [XLEN-1:0] sepc
);

  logic [XLEN-1:0] sscratch;
  logic [XLEN-1:0] scause;
  logic [XLEN-1:0] cycle;

  always_comb begin
    rdata = '0;
    case (addr)
      CSR_SSCRATCH: rdata = sscratch;
      CSR_SEPC:     rdata = sepc;
      CSR_SCAUSE:   rdata = scause;
      CSR_STVEC:    rdata = stvec;
      CSR_CYCLE:    rdata = cycle;
      default:      rdata = '0;
    endcase
  end

  // cycle is read-only: set writes to it fall through to the default arm
  always_ff @(posedge clk) begin
    if (rst) begin
      sscratch <= '0;
      sepc     <= '0;
      scause   <= '0;
      stvec    <= XLEN'(TRAP_VEC);
      cycle    <= '0;
    end else begin
      cycle <= cycle + XLEN'(1);
      if (set_en) begin
        case (addr)
          CSR_SSCRATCH: sscratch <= sscratch | set_mask;
          CSR_SEPC:     sepc     <= sepc | set_mask;
          CSR_SCAUSE:   scause   <= scause | set_mask;
          CSR_STVEC:    stvec    <= stvec | set_mask;
          default:      ;
        endcase
      end
      if (trap_en) begin
        sepc   <= trap_pc;
        scause <= {{(XLEN-8){1'b0}}, trap_cause};
      end
    end
  end

endmodule

// File: rtl/trap_csr_unit.sv
// rtl/trap_csr_unit.sv - EX-stage trap/CSR unit: event priority, redirect FSM, CSR file
module trap_csr_unit
  import cpu_csr_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            stall,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_int,
  input  logic [7:0]      ex_scause,
  input  logic            ex_mret,
  input  logic            ex_csrrs,
  input  logic [11:0]     ex_csr_addr,
  input  logic [4:0]      ex_rs1_idx,
  input  logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] csr_rdata,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            in_trap
);

  trap_state_t     state;
  logic            acc;
  logic            do_trap;
  logic            do_mret;
  logic            do_set;
  logic [XLEN-1:0] stvec;
  logic [XLEN-1:0] sepc;

  // ex_int outranks ex_mret, which outranks ex_csrrs
  assign acc     = ex_valid & ~stall & (state == ST_IDLE);
  assign do_trap = acc & ex_int;
  assign do_mret = acc & ex_mret & ~ex_int;
  assign do_set  = acc & ex_csrrs & ~ex_int & ~ex_mret & (ex_rs1_idx != 5'd0);

  csr_file #(
    .XLEN     (XLEN),
    .TRAP_VEC (TRAP_VEC)
  ) u_csr_file (
    .clk        (clk),
    .rst        (rst),
    .addr       (ex_csr_addr),
    .rdata      (csr_rdata),
    .set_en     (do_set),
    .set_mask   (ex_rs1_data),
    .trap_en    (do_trap),
    .trap_pc    (ex_pc),
    .trap_cause (ex_scause),
    .stvec      (stvec),
    .sepc       (sepc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      in_trap        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          redirect_valid <= 1'b0;
          if (do_trap) begin
            state          <= ST_REDIR;
            redirect_valid <= 1'b1;
            redirect_pc    <= stvec;
            in_trap        <= 1'b1;
          end else if (do_mret) begin
            state          <= ST_REDIR;
            redirect_valid <= 1'b1;
            redirect_pc    <= sepc + XLEN'(4);
            in_trap        <= 1'b0;
          end
        end
        ST_REDIR: begin
          state          <= ST_IDLE;
          redirect_valid <= 1'b0;
        end
        default: begin
          state          <= ST_IDLE;
          redirect_valid <= 1'b0;
        end
      endcase
    end
  end

  assign flush = redirect_valid;

endmodule

// File: tb/tb_trap_csr_unit.sv
// tb/tb_trap_csr_unit.sv - directed bench with redirect scoreboard for trap_csr_unit
module tb_trap_csr_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        stall;
  logic [31:0] ex_pc;
  logic        ex_int;
  logic [7:0]  ex_scause;
  logic        ex_mret;
  logic        ex_csrrs;
  logic [11:0] ex_csr_addr;
  logic [4:0]  ex_rs1_idx;
  logic [31:0] ex_rs1_data;
  logic [31:0] csr_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        in_trap;

  int          total_checks = 0;
  int          passed_checks = 0;
  logic [31:0] exp_q[$];

  trap_csr_unit #(
    .XLEN     (32),
    .TRAP_VEC (32'h0000_0100)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .stall          (stall),
    .ex_pc          (ex_pc),
    .ex_int         (ex_int),
    .ex_scause      (ex_scause),
    .ex_mret        (ex_mret),
    .ex_csrrs       (ex_csrrs),
    .ex_csr_addr    (ex_csr_addr),
    .ex_rs1_idx     (ex_rs1_idx),
    .ex_rs1_data    (ex_rs1_data),
    .csr_rdata      (csr_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .in_trap        (in_trap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    assert (obs === exp) passed_checks++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Each clock: a queued redirect target must appear now, otherwise no redirect at all
  task automatic tick();
    logic [31:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("redirect_valid", 32'(redirect_valid), 32'd1);
      chk("redirect_pc", redirect_pc, e);
      chk("flush", 32'(flush), 32'd1);
    end else begin
      chk("no_redirect", 32'(redirect_valid), 32'd0);
      chk("no_flush", 32'(flush), 32'd0);
    end
  endtask

  task automatic rd(input logic [11:0] a, input string tag, input logic [31:0] e);
    ex_csr_addr = a;
    #1;
    chk(tag, csr_rdata, e);
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; stall = 1'b0; ex_pc = '0; ex_int = 1'b0; ex_scause = '0;
    ex_mret = 1'b0; ex_csrrs = 1'b0; ex_rs1_idx = '0; ex_rs1_data = '0;
  endtask

  initial begin
    rst = 1'b1;
    ex_csr_addr = 12'h000;
    idle_inputs();
    tick();
    tick();
    chk("rst_in_trap", 32'(in_trap), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    rd(12'h105, "rst_stvec", 32'h100);
    rd(12'h141, "rst_sepc", 32'h0);
    rd(12'h142, "rst_scause", 32'h0);
    rd(12'h140, "rst_sscratch", 32'h0);
    rd(12'h7FF, "unmapped_read", 32'h0);
    rd(12'hC00, "cycle_0", 32'd0);
    rst = 1'b0;
    tick();
    chk("cycle_1", csr_rdata, 32'd1);
    tick();
    chk("cycle_2", csr_rdata, 32'd2);

    // ECALL at 0x40, then a wrong-path ECALL held during REDIR
    ex_valid = 1'b1; ex_int = 1'b1; ex_scause = 8'h08; ex_pc = 32'h40;
    exp_q.push_back(32'h100);
    tick();
    chk("ecall_in_trap", 32'(in_trap), 32'd1);
    ex_pc = 32'hC0; ex_scause = 8'h02;
    tick();
    idle_inputs();
    rd(12'h141, "ecall_sepc", 32'h40);
    rd(12'h142, "ecall_scause", 32'h08);
    tick();

    // MRET returns to sepc + 4
    ex_valid = 1'b1; ex_mret = 1'b1;
    exp_q.push_back(32'h44);
    tick();
    chk("mret_in_trap", 32'(in_trap), 32'd0);
    idle_inputs();
    tick();

    // CSRRS stvec with x5 = 0x200, then rs1 = x0 leaves it alone
    ex_csr_addr = 12'h105;
    ex_valid = 1'b1; ex_csrrs = 1'b1; ex_rs1_idx = 5'd5; ex_rs1_data = 32'h200;
    #1;
    chk("csrrs_old", csr_rdata, 32'h100);
    tick();
    chk("csrrs_new", csr_rdata, 32'h300);
    ex_rs1_idx = 5'd0; ex_rs1_data = 32'hFFFF_0000;
    tick();
    chk("csrrs_x0", csr_rdata, 32'h300);
    ex_valid = 1'b0;
    rd(12'h140, "sscratch_old", 32'h0);
    ex_valid = 1'b1; ex_rs1_idx = 5'd3; ex_rs1_data = 32'h0000_0011;
    tick();
    chk("sscratch_new", csr_rdata, 32'h11);
    ex_valid = 1'b0;
    rd(12'h7FF, "unmapped_prep", 32'h0);
    ex_valid = 1'b1; ex_rs1_data = 32'hFFFF_FFFF;
    tick();
    chk("unmapped_write", csr_rdata, 32'h0);
    idle_inputs();

    // Illegal-instruction trap held off by 3 stall cycles
    ex_valid = 1'b1; ex_int = 1'b1; ex_scause = 8'h02; ex_pc = 32'h60; stall = 1'b1;
    tick();
    tick();
    tick();
    chk("stall_no_trap", 32'(in_trap), 32'd0);
    stall = 1'b0;
    exp_q.push_back(32'h300);
    tick();
    idle_inputs();
    rd(12'h141, "stall_sepc", 32'h60);
    rd(12'h142, "stall_scause", 32'h02);
    tick();

    ex_valid = 1'b1; ex_mret = 1'b1;
    exp_q.push_back(32'h64);
    tick();
    idle_inputs();
    tick();

    // ex_int and ex_mret together: trap wins
    ex_valid = 1'b1; ex_int = 1'b1; ex_mret = 1'b1; ex_scause = 8'h08; ex_pc = 32'h80;
    exp_q.push_back(32'h300);
    tick();
    chk("both_in_trap", 32'(in_trap), 32'd1);
    idle_inputs();
    rd(12'h141, "both_sepc", 32'h80);
    tick();

    // Reset beats a simultaneous trap
    ex_valid = 1'b1; ex_int = 1'b1; ex_pc = 32'hA0; rst = 1'b1;
    tick();
    idle_inputs();
    rst = 1'b0;
    chk("rst_evt_in_trap", 32'(in_trap), 32'd0);
    rd(12'h105, "rst_evt_stvec", 32'h100);
    rd(12'h141, "rst_evt_sepc", 32'h0);
    tick();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/trap_csr_unit.md
# trap_csr_unit

Trap and CSR unit for the pipelined RISC-V core. Sits directly downstream of the decoder in the EX stage and consumes its exception outputs (SCAUSE, INT_Signal, MRET, CSRRS). Holds the supervisor trap CSRs, returns CSRRS read data to the writeback mux (WDSel = 2'b11), and issues a one-cycle registered PC redirect plus pipeline flush on ECALL/illegal-instruction entry and on MRET.

## Interface
- `XLEN`, 32: datapath width.
- `TRAP_VEC`, 32'h0000_0100: reset value of `stvec`.
- `clk` in 1: single clock, all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ex_valid` in 1: EX-stage instruction is real (not a bubble).
- `stall` in 1: pipeline hold; no events are accepted while high.
- `ex_pc` in XLEN: PC of the EX instruction.
- `ex_int` in 1: decoded INT_Signal.
- `ex_scause` in 8: decoded SCAUSE.
- `ex_mret` in 1: decoded MRET.
- `ex_csrrs` in 1: decoded CSRRS.
- `ex_csr_addr` in 12: instr[31:20].
- `ex_rs1_idx` in 5: rs1 index.
- `ex_rs1_data` in XLEN: forwarded rs1 value (set mask).
- `csr_rdata` out XLEN: combinational old value of the addressed CSR.
- `redirect_valid` out 1: next-PC override, one cycle.
- `redirect_pc` out XLEN: redirect target.
- `flush` out 1: kill IF/ID/EX; equal to `redirect_valid`.
- `in_trap` out 1: handler active.

## Operation
- CSRs: `sscratch` 0x140, `sepc` 0x141, `scause` 0x142, `stvec` 0x105, `cycle` 0xC00 (read-only, free-running, +1 every cycle, wraps at 2^32). Any other address reads 0, and writes to it are dropped.
- Accept condition `acc` = `ex_valid` & ~`stall` & state==IDLE.
- FSM states:
  - IDLE → REDIR on `acc` & (`ex_int` | `ex_mret`).
  - REDIR → IDLE unconditionally.
  - In REDIR all `ex_*` inputs are wrong-path and ignored; `stall` does not extend REDIR.
- Trap entry (`acc` & `ex_int`):
  - `sepc` ← `ex_pc`; `scause` ← {24'b0, `ex_scause`}; `in_trap` ← 1.
  - Latched target = `stvec`.
  - Trapping while `in_trap`=1 is allowed: `sepc`/`scause` are overwritten.
- MRET (`acc` & `ex_mret` & ~`ex_int`): latched target = `sepc` + 4; `in_trap` ← 0. MRET with `in_trap`=0 still redirects.
- Priority: `ex_int` over `ex_mret` over `ex_csrrs`.
- CSRRS (`acc` & `ex_csrrs` & ~`ex_int`): `csr_rdata` = old value. If `ex_rs1_idx` ≠ 0, CSR ← old | `ex_rs1_data` at the edge. Writes to `cycle` are ignored.
- A CSRRS write to `stvec` in the same cycle as a trap cannot occur (`ex_int` wins).
- `csr_rdata` is valid whenever `ex_csr_addr` is stable, independent of `acc`.

## Timing
- Redirect latency: event accepted at edge N; `redirect_valid`=`flush`=1 and `redirect_pc` valid during cycle N+1 only.
- CSR write visible to `csr_rdata` the cycle after the accepting edge. Back-to-back CSRRS instructions read updated values.
- `cycle` increments during stall and REDIR.
- Reset: `sepc`=0, `scause`=0, `sscratch`=0, `stvec`=`TRAP_VEC`, `cycle`=0, state=IDLE, `redirect_valid`=0, `flush`=0, `redirect_pc`=0, `in_trap`=0. Reset asserted in REDIR aborts the redirect the next cycle. Reset wins over any simultaneous event.

## Structure
- Shared package `cpu_csr_pkg`:
  - CSR address constants.
  - Cause codes ECALL 8'h08, ILLEGAL 8'h02.
  - FSM state enum {IDLE, REDIR}.
  - WDSel encoding 2'b11 = CSR.
- One sub-module, `csr_file`: register storage, read mux and set-bits write port. FSM, priority logic and redirect register stay in the top level.

## Test plan
- Reset → `stvec`=0x100, `cycle` counts 0,1,2…, no redirect.
- ECALL (`ex_int`=1, `ex_scause`=0x08, `ex_pc`=0x40) → next cycle `redirect_pc`=0x100, `flush`=1 for exactly 1 cycle; then `sepc`=0x40, `scause`=0x08, `in_trap`=1.
- MRET after that trap → next cycle `redirect_pc`=0x44, `in_trap`=0.
- CSRRS `stvec`, rs1=x5=0x0000_0200 → `csr_rdata`=0x100; next read = 0x300. Same with rs1=x0 → no change.
- ECALL with `stall`=1 for 3 cycles then 0 → redirect asserted only after stall release. ECALL presented during REDIR → ignored.
- `ex_int` and `ex_mret` together at `ex_pc`=0x80 → trap to `stvec`, `sepc`=0x80, `in_trap`=1.
